// File: rtl/memarb4ifmo.sv
// Shared memory port arbiter for IF (read-only) and MO (read/write); registered command, one cycle after grant.
// Read data returns MEM_LAT+2 cycles after grant. Losing requester sees stall; MO wins unless IF has waited STARVE_MAX grants.
module memarb4ifmo #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 12,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mo_req,
    input  logic              mo_we,
    input  logic [ADDR_W-1:0] mo_addr,
    input  logic [DATA_W-1:0] mo_wdata,
    output logic              mo_gnt,
    output logic              mo_rvalid,
    output logic [DATA_W-1:0] mo_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mo
);

    localparam logic [2:0] SMAX = 3'(STARVE_MAX);

    logic [2:0]         starve_cnt;
    logic               if_force;
    logic               cmd_own;    // owner of the command on the port: 1 = MO
    logic [MEM_LAT-1:0] pipe_vld;
    logic [MEM_LAT-1:0] pipe_own;
    logic               ret_if;
    logic               ret_mo;

    always_comb begin
        if_force = if_req && (starve_cnt == SMAX);
        if_gnt   = !rst && if_req && (!mo_req || if_force);
        mo_gnt   = !rst && mo_req && !if_force;
        stall_if = if_req && !if_gnt;
        stall_mo = mo_req && !mo_gnt;
        ret_if   = pipe_vld[MEM_LAT-1] && !pipe_own[MEM_LAT-1];
        ret_mo   = pipe_vld[MEM_LAT-1] &&  pipe_own[MEM_LAT-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cmd_own    <= 1'b0;
            pipe_vld   <= '0;
            pipe_own   <= '0;
            if_rvalid  <= 1'b0;
            mo_rvalid  <= 1'b0;
            if_rdata   <= '0;
            mo_rdata   <= '0;
        end else begin
            if (!if_req || if_gnt)
                starve_cnt <= '0;
            else if (mo_gnt && starve_cnt != SMAX)
                starve_cnt <= starve_cnt + 3'd1;

            mem_en <= if_gnt || mo_gnt;
            mem_we <= mo_gnt && mo_we;
            if (mo_gnt) begin
                mem_addr  <= mo_addr;
                mem_wdata <= mo_wdata;
                cmd_own   <= 1'b1;
            end else if (if_gnt) begin
                mem_addr  <= if_addr;
                cmd_own   <= 1'b0;
            end

            // Read tags enter during their command cycle and exit when mem_rdata is valid.
            pipe_vld[0] <= mem_en && !mem_we;
            pipe_own[0] <= cmd_own;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_own[i] <= pipe_own[i-1];
            end

            if_rvalid <= ret_if;
            mo_rvalid <= ret_mo;
            if (ret_if) if_rdata <= mem_rdata;
            if (ret_mo) mo_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_memarb4ifmo.sv
// Directed bench for memarb4ifmo; scoreboard queues are filled by the stimulus and drained by a negedge monitor.
module tb_memarb4ifmo;

    localparam int LAT  = 2;
    localparam int SMAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mo_req, mo_we;
    logic [11:0] if_addr, mo_addr, mo_wdata;
    logic        if_gnt, mo_gnt, if_rvalid, mo_rvalid;
    logic [11:0] if_rdata, mo_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_if, stall_mo;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [11:0] addr;
        logic        we;
        logic [11:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic        own;
        logic [11:0] data;
    } ret_t;

    cmd_t exp_cmd[$];
    ret_t exp_ret[$];

    memarb4ifmo #(.ADDR_W(12), .DATA_W(12), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mo_req(mo_req), .mo_we(mo_we), .mo_addr(mo_addr), .mo_wdata(mo_wdata),
        .mo_gnt(mo_gnt), .mo_rvalid(mo_rvalid), .mo_rdata(mo_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mo(stall_mo)
    );

    always #5 clk = ~clk;

    // Memory model: data = addr ^ 0xFFF, presented LAT cycles after the command cycle.
    logic [11:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= mem_addr ^ 12'hFFF;
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mem_rdata = mpipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            if (exp_cmd.size() == 0) begin
                checks++; errors++;
                $display("FAIL cmd_unexpected got addr %0h we %0b want no command", mem_addr, mem_we);
            end else begin
                cmd_t c;
                c = exp_cmd.pop_front();
                chk("cmd_addr", 32'(mem_addr), 32'(c.addr));
                chk("cmd_we", 32'(mem_we), 32'(c.we));
                if (c.we) chk("cmd_wdata", 32'(mem_wdata), 32'(c.wdata));
            end
        end
        if (if_rvalid === 1'b1 || mo_rvalid === 1'b1) begin
            if (exp_ret.size() == 0) begin
                checks++; errors++;
                $display("FAIL ret_unexpected got if_rvalid %0b mo_rvalid %0b want none", if_rvalid, mo_rvalid);
            end else begin
                ret_t r;
                r = exp_ret.pop_front();
                chk("ret_if_rvalid", 32'(if_rvalid), 32'(!r.own));
                chk("ret_mo_rvalid", 32'(mo_rvalid), 32'(r.own));
                chk("ret_data", 32'(r.own ? mo_rdata : if_rdata), 32'(r.data));
            end
        end
    end

    // One cycle: drive requests, check grants/stalls at negedge, queue expected command and return.
    task automatic cyc(input logic ir, input logic [11:0] ia, input logic mr, input logic mw,
                       input logic [11:0] ma, input logic [11:0] md,
                       input logic eif, input logic emo, input logic ret_en, input string tag);
        if_req = ir; if_addr = ia; mo_req = mr; mo_we = mw; mo_addr = ma; mo_wdata = md;
        @(negedge clk);
        chk({tag, "_if_gnt"}, 32'(if_gnt), 32'(eif));
        chk({tag, "_mo_gnt"}, 32'(mo_gnt), 32'(emo));
        chk({tag, "_stall_if"}, 32'(stall_if), 32'(ir && !eif));
        chk({tag, "_stall_mo"}, 32'(stall_mo), 32'(mr && !emo));
        if (eif) begin
            exp_cmd.push_back('{addr: ia, we: 1'b0, wdata: 12'h000});
            if (ret_en) exp_ret.push_back('{own: 1'b0, data: ia ^ 12'hFFF});
        end
        if (emo) begin
            exp_cmd.push_back('{addr: ma, we: mw, wdata: md});
            if (ret_en && !mw) exp_ret.push_back('{own: 1'b1, data: ma ^ 12'hFFF});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        if_req = 1'b0; mo_req = 1'b0; mo_we = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mem_en"}, 32'(mem_en), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_if_rvalid"}, 32'(if_rvalid), 0);
        chk({tag, "_mo_rvalid"}, 32'(mo_rvalid), 0);
        chk({tag, "_if_rdata"}, 32'(if_rdata), 0);
        chk({tag, "_mo_rdata"}, 32'(mo_rdata), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mo_n;
        logic [11:0] ia;
        rst = 1'b1; if_req = 1'b1; mo_req = 1'b1; mo_we = 1'b0;
        if_addr = 12'h000; mo_addr = 12'h000; mo_wdata = 12'h000;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_if_gnt", 32'(if_gnt), 0);
        chk("rst_mo_gnt", 32'(mo_gnt), 0);
        chk("rst_stall_if", 32'(stall_if), 1);
        chk("rst_stall_mo", 32'(stall_mo), 1);
        chk_outputs_zero("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // IF-only read
        cyc(1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b1, "if_only");
        idle(LAT + 3);

        // Conflict: MO first, IF next cycle; returns in that order
        cyc(1'b1, 12'h020, 1'b1, 1'b0, 12'h030, 12'h000, 1'b0, 1'b1, 1'b1, "conf0");
        cyc(1'b1, 12'h020, 1'b0, 1'b0, 12'h030, 12'h000, 1'b1, 1'b0, 1'b1, "conf1");
        idle(LAT + 3);

        // MO write, no return expected
        cyc(1'b0, 12'h000, 1'b1, 1'b1, 12'h0FF, 12'hABC, 1'b0, 1'b1, 1'b1, "mo_wr");
        idle(LAT + 3);

        // Starvation: MO held high, IF forced through every 4th grant
        mo_n = 0;
        ia = 12'h200;
        for (int i = 0; i < 8; i++) begin
            logic w_if;
            w_if = (i == 3) || (i == 7);
            cyc(1'b1, ia, 1'b1, 1'b0, 12'(12'h100 + mo_n), 12'h000, w_if, !w_if, 1'b1, "starve");
            if (w_if) ia = ia + 12'h001;
            else mo_n++;
        end
        idle(LAT + 3);

        // Reset with reads in flight
        cyc(1'b1, 12'h400, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0, "midrst0");
        cyc(1'b0, 12'h000, 1'b1, 1'b0, 12'h410, 12'h000, 1'b0, 1'b1, 1'b0, "midrst1");
        rst = 1'b1; if_req = 1'b1; mo_req = 1'b1;
        @(negedge clk);
        chk("midrst_if_gnt", 32'(if_gnt), 0);
        chk("midrst_mo_gnt", 32'(mo_gnt), 0);
        chk("midrst_stall_if", 32'(stall_if), 1);
        chk("midrst_stall_mo", 32'(stall_mo), 1);
        @(posedge clk); #1;
        rst = 1'b0; if_req = 1'b0; mo_req = 1'b0;
        @(negedge clk);
        chk_outputs_zero("post_rst");
        idle(LAT + 4);

        // Alternating back-to-back reads
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                cyc(1'b1, 12'(12'h300 + i), 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b1, "alt_if");
            else
                cyc(1'b0, 12'h000, 1'b1, 1'b0, 12'(12'h300 + i), 12'h000, 1'b0, 1'b1, 1'b1, "alt_mo");
        end
        idle(LAT + 4);

        chk("drain_cmd_q", 32'(exp_cmd.size()), 0);
        chk("drain_ret_q", 32'(exp_ret.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memarb4ifmo.md
Name: memarb4ifmo

Overview:
- Arbiter and sequencer for the single shared 12-bit memory port.
- Two requesters share the port: instruction fetch (IF, read-only) and the memory-operation stage (MO, read/write).
- Grants at most one command per cycle, issues it as a registered command, and tracks in-flight reads by owner through a fixed-latency return pipe.
- Drives stall flags back to the IF and MO pipeline stages.

Parameters:
- ADDR_W, 12, address width.
- DATA_W, 12, data width.
- MEM_LAT, 1, memory read latency in cycles from command cycle to mem_rdata valid; legal range 1..4.
- STARVE_MAX, 3, maximum consecutive MO grants while IF is waiting before IF is forced through; legal range 1..7.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  IF request; held with if_addr stable until granted.
- if_addr  in  ADDR_W  IF read address.
- if_gnt  out  1  IF transfer accepted this cycle (combinational).
- if_rvalid  out  1  IF read data valid, one-cycle pulse.
- if_rdata  out  DATA_W  IF read data; held between pulses.
- mo_req  in  1  MO request; held stable until granted.
- mo_we  in  1  1 = write, 0 = read.
- mo_addr  in  ADDR_W  MO address.
- mo_wdata  in  DATA_W  MO write data.
- mo_gnt  out  1  MO transfer accepted this cycle (combinational).
- mo_rvalid  out  1  MO read data valid pulse.
- mo_rdata  out  DATA_W  MO read data; held between pulses.
- mem_en  out  1  memory command valid.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the command cycle.
- stall_if  out  1  if_req & ~if_gnt.
- stall_mo  out  1  mo_req & ~mo_gnt.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Handshake: a transfer occurs on a rising edge where req & gnt.
  - The requester may present the next request in the same cycle, so back-to-back grants every cycle are legal.
  - If req is low, gnt is 0.
- Arbitration (combinational, cycle k):
  - MO has priority.
  - Exception: IF wins when if_req=1 and starve_cnt==STARVE_MAX.
  - if_gnt and mo_gnt are never both 1.
- starve_cnt (3-bit register), updated on each edge:
  - MO granted and if_req=1 → increment, saturating at STARVE_MAX.
  - IF granted, or if_req=0 → clear to 0.
  - No grant and if_req=1 → hold.
- Command issue:
  - Registered; a grant in cycle k drives mem_en=1 with the winner's addr/we/wdata in cycle k+1.
  - IF commands always have mem_we=0.
  - With no grant, mem_en=0 and mem_we=0; mem_addr/mem_wdata hold their last values.
- Return pipe:
  - MEM_LAT-deep shift register of {valid, owner}; a read command enters the pipe in its command cycle.
  - Writes do not enter the pipe and never produce rvalid.
  - When a tag exits in cycle k+1+MEM_LAT, the owner's rdata register captures mem_rdata, and the owner's rvalid is 1 in cycle k+2+MEM_LAT.
- Latency and ordering:
  - Total read latency from grant to rvalid is MEM_LAT+2 cycles.
  - Full throughput is one read per cycle; returns arrive in issue order.
- Simultaneous events: a new grant and a read return in the same cycle proceed independently; no extra stall is inserted.
- Reset:
  - mem_en, mem_we, mem_addr, mem_wdata, if_rvalid, mo_rvalid, if_rdata, mo_rdata, starve_cnt and all pipe tags go to 0.
  - gnt outputs are 0 while rst=1. stall_if/stall_mo follow req during reset.
- Reset mid-operation: in-flight reads are discarded; no rvalid is produced in any cycle after rst deasserts for commands issued before reset.

Test Plan:
1. MEM_LAT=1, IF only, if_req=1, if_addr=0x010 in cycle 0 → if_gnt=1 in cycle 0; mem_en=1, mem_addr=0x010, mem_we=0 in cycle 1; model drives 0x5A5 in cycle 2; if_rvalid=1, if_rdata=0x5A5 in cycle 3.
2. IF and MO read both requesting in cycle 0 (IF 0x020, MO 0x030) → mo_gnt=1, stall_if=1 in cycle 0; if_gnt=1 in cycle 1; mem_addr=0x030 then 0x020; mo_rvalid before if_rvalid, each with the correct data.
3. MO write, mo_we=1, mo_addr=0x0FF, mo_wdata=0xABC → mem_en=1, mem_we=1, addr 0x0FF, wdata 0xABC one cycle later; no mo_rvalid or if_rvalid at any time.
4. STARVE_MAX=3, mo_req held high continuously, if_req high from cycle 0 → MO granted in cycles 0–2, IF in cycle 3, MO in cycle 4; starve_cnt back to 0 after cycle 3.
5. MEM_LAT=3, reads granted in cycles 0–1, rst=1 in cycle 2 for one cycle → no if_rvalid or mo_rvalid in any subsequent cycle; all outputs 0 during the cycle after the reset edge.
6. MEM_LAT=2, alternating IF/MO reads every cycle for 8 cycles, memory model returns addr^0xFFF → each rvalid routed to the correct owner, in order, with data = addr^0xFFF; no dropped or duplicated pulses.
